// File: rtl/watch_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : watch_seg_scan
//  Purpose  : Scans four BCD time digits onto a 4-digit common-anode
//             7-segment display. The digit being calibrated blinks, and the
//             hour-low decimal point shows the 1 Hz second indicator (colon).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1  system clock
//    rstn        in   1  synchronous active-low reset
//    hour_h      in   4  BCD hour tens
//    hour_l      in   4  BCD hour units
//    min_h       in   4  BCD minute tens
//    min_l       in   4  BCD minute units
//    second_led  in   1  second indicator, 1 = colon lit
//    state_flag  in   3  0/5..7 normal, 1..4 = min_l/min_h/hour_l/hour_h
//                        under calibration
//    seg_sel     out  4  active-low one-hot digit enable, bit0 = min_l
//    seg_data    out  8  active-low segments {dp,g,f,e,d,c,b,a}
//
//  Build option
//    LEADING_ZERO_BLANK_EN : when defined, a zero hour-tens digit is blanked
//                            unless that digit is under calibration.
// ============================================================================
module watch_seg_scan #(
    parameter int CLK_FRE   = 50_000_000,
    parameter int SCAN_FRE  = 1000,
    parameter int BLINK_FRE = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] hour_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic       second_led,
    input  logic [2:0] state_flag,
    output logic [3:0] seg_sel,
    output logic [7:0] seg_data
);

    // SCAN_DIV must be at least 2 for the scan tick to be a single cycle.
    localparam int SCAN_DIV   = CLK_FRE / SCAN_FRE;
    localparam int BLINK_HALF = CLK_FRE / (2 * BLINK_FRE);
    localparam int SCAN_W     = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [6:0]         SEG_BLANK  = 7'h7F;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0]  scan_cnt_q,    scan_cnt_d;
    logic [1:0]         idx_q,         idx_d;
    logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [2:0]         flag_prev_q,   flag_prev_d;
    logic [3:0]         snap_hh_q,     snap_hh_d;
    logic [3:0]         snap_hl_q,     snap_hl_d;
    logic [3:0]         snap_mh_q,     snap_mh_d;
    logic [3:0]         snap_ml_q,     snap_ml_d;
    logic               snap_sl_q,     snap_sl_d;
    logic [3:0]         seg_sel_q,     seg_sel_d;
    logic [7:0]         seg_data_q,    seg_data_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       scan_tick;
    logic       flag_chg;
    logic       phase_eff;
    logic       blank_digit;
    logic [3:0] digit_val;
    logic [6:0] seg7;
    logic       dp_n;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_cnt_d    = scan_cnt_q;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        flag_prev_d   = state_flag;
        snap_hh_d     = snap_hh_q;
        snap_hl_d     = snap_hl_q;
        snap_mh_d     = snap_mh_q;
        snap_ml_d     = snap_ml_q;
        snap_sl_d     = snap_sl_q;

        // Scan divider and digit index
        scan_tick = (scan_cnt_q == SCAN_LAST);
        if (scan_tick) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
            // Capture on the last-digit tick so the next frame is built
            // entirely from one coherent time value.
            if (idx_q == 2'd3) begin
                snap_hh_d = hour_h;
                snap_hl_d = hour_l;
                snap_mh_d = min_h;
                snap_ml_d = min_l;
                snap_sl_d = second_led;
            end
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end

        // Blink timing; a new calibration selection restarts in the
        // visible half so the operator sees the digit straight away.
        flag_chg = (state_flag != flag_prev_q);
        if (flag_chg) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        end

        // Treat the phase as visible in the change cycle itself; otherwise
        // a stale blank phase could leak onto the newly selected digit.
        phase_eff = flag_chg ? 1'b0 : blink_phase_q;

        case (idx_q)
            2'd0:    digit_val = snap_ml_q;
            2'd1:    digit_val = snap_mh_q;
            2'd2:    digit_val = snap_hl_q;
            default: digit_val = snap_hh_q;
        endcase

        blank_digit = (state_flag >= 3'd1) && (state_flag <= 3'd4) &&
                      ((state_flag - 3'd1) == {1'b0, idx_q});

        seg7 = seg_decode(digit_val);
        if (blank_digit && phase_eff) begin
            seg7 = SEG_BLANK;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q == 2'd3) && (snap_hh_q == 4'd0) && (state_flag != 3'd4)) begin
            seg7 = SEG_BLANK;
        end
`endif

        dp_n = ~((idx_q == 2'd2) && snap_sl_q);

        seg_sel_d  = ~(4'b0001 << idx_q);
        seg_data_d = {dp_n, seg7};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            scan_cnt_q    <= '0;
            idx_q         <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            flag_prev_q   <= 3'd0;
            snap_hh_q     <= 4'd0;
            snap_hl_q     <= 4'd0;
            snap_mh_q     <= 4'd0;
            snap_ml_q     <= 4'd0;
            snap_sl_q     <= 1'b0;
            seg_sel_q     <= 4'b1111;
            seg_data_q    <= 8'hFF;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            flag_prev_q   <= flag_prev_d;
            snap_hh_q     <= snap_hh_d;
            snap_hl_q     <= snap_hl_d;
            snap_mh_q     <= snap_mh_d;
            snap_ml_q     <= snap_ml_d;
            snap_sl_q     <= snap_sl_d;
            seg_sel_q     <= seg_sel_d;
            seg_data_q    <= seg_data_d;
        end
    end

    assign seg_sel  = seg_sel_q;
    assign seg_data = seg_data_q;

endmodule
`default_nettype wire

// File: tb/tb_watch_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_watch_seg_scan
//  Purpose  : Directed self-checking bench for watch_seg_scan with
//             CLK_FRE=1200, SCAN_FRE=100 (12 cycles/digit) and
//             BLINK_FRE=10 (60 cycles per blink half-period).
//  Revision : 1.0  initial release
// ============================================================================
module tb_watch_seg_scan;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] hour_h, hour_l, min_h, min_l;
    logic       second_led;
    logic [2:0] state_flag;
    logic [3:0] seg_sel;
    logic [7:0] seg_data;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_EXP = 8'hFF;
`else
    localparam logic [7:0] LZ_EXP = 8'hC0;
`endif

    watch_seg_scan #(
        .CLK_FRE   (1200),
        .SCAN_FRE  (100),
        .BLINK_FRE (10)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hour_h     (hour_h),
        .hour_l     (hour_l),
        .min_h      (min_h),
        .min_l      (min_l),
        .second_led (second_led),
        .state_flag (state_flag),
        .seg_sel    (seg_sel),
        .seg_data   (seg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] sel, input logic [7:0] data);
        check_eq({tag, " sel"},  {4'h0, seg_sel}, {4'h0, sel});
        check_eq({tag, " data"}, seg_data, data);
    endtask

    // Bounded wait (sampling on negedges) until the given digit is enabled.
    task automatic wait_sel(input logic [3:0] s, input string tag);
        int i = 0;
        while (seg_sel !== s && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (seg_sel !== s) check_eq({tag, " wait_sel timeout"}, {4'h0, seg_sel}, {4'h0, s});
    endtask

    // Aligns to the next frame start and checks every cycle of all four
    // digits. Returns on the last cycle of digit 3.
    task automatic check_frame(input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3,
                               input string tag);
        logic [7:0] exp_d [4];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
        wait_sel(4'b0111, tag);
        wait_sel(4'b1110, tag);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 12; c++) begin
                check_out($sformatf("%s d%0d c%0d", tag, d, c),
                          ~(4'b0001 << d), exp_d[d]);
                if (!(d == 3 && c == 11)) @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [3:0] prev_sel;
        logic       found;
        logic [7:0] exp_b;

        rstn = 1'b0;
        hour_h = 4'd1; hour_l = 4'd2; min_h = 4'd3; min_l = 4'd4;
        second_led = 1'b0;
        state_flag = 3'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check_out("reset", 4'b1111, 8'hFF);
        rstn = 1'b1;

        // First frame after reset comes from the zeroed snapshot; 12:34
        // appears once captured at the first index-3 tick.
        for (int k = 1; k <= 49; k++) begin
            @(negedge clk);
            case (k)
                1, 12:  check_out($sformatf("first k%0d", k), 4'b1110, 8'hC0);
                13:     check_out("first k13", 4'b1101, 8'hC0);
                25, 36: check_out($sformatf("first k%0d", k), 4'b1011, 8'hC0);
                37, 48: check_out($sformatf("first k%0d", k), 4'b0111, 8'hC0);
                49:     check_out("first k49", 4'b1110, 8'h99);
                default: ;
            endcase
        end
        check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, "t1234");

        // Colon on hour-low digit
        hour_l = 4'd3; second_led = 1'b1;
        wait_sel(4'b1101, "colon");
        check_frame(8'h99, 8'hB0, 8'h30, 8'hF9, "colon");

        // Mid-frame change is not visible until the next frame
        wait_sel(4'b1110, "snap");
        min_l = 4'd5;
        repeat (5) begin
            @(negedge clk);
            check_out("snap_hold", 4'b1110, 8'h99);
        end
        check_frame(8'h92, 8'hB0, 8'h30, 8'hF9, "snap_new");

        // Blink of min_h: visible for the first 60 cycles, then blank
        @(negedge clk);
        state_flag = 3'd2;
        for (int k = 0; k < 240; k++) begin
            @(negedge clk);
            if (seg_sel == 4'b1101) begin
                exp_b = (k >= 1 && ((k - 1) / 60) % 2 == 1) ? 8'hFF : 8'hB0;
                check_eq($sformatf("blink k%0d", k), seg_data, exp_b);
            end else if (seg_sel == 4'b1110) begin
                check_eq($sformatf("blink_other k%0d", k), seg_data, 8'h92);
            end
        end
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            prev_sel = seg_sel;
            @(negedge clk);
            if (prev_sel == 4'b1110 && seg_sel == 4'b1101 && seg_data == 8'hFF) found = 1'b1;
        end
        check_eq("blink_find_blank", {7'd0, found}, 8'h01);
        state_flag = 3'd0;
        @(negedge clk);
        check_out("blink_stop", 4'b1101, 8'hB0);

        // Invalid BCD on min_h
        hour_h = 4'd1; hour_l = 4'd3; min_h = 4'hC; min_l = 4'd4; second_led = 1'b0;
        wait_sel(4'b1101, "bad_bcd");
        check_frame(8'h99, 8'hFF, 8'hB0, 8'hF9, "bad_bcd");

        // 23:59 with a non-calibration flag value (never blanks)
        hour_h = 4'd2; hour_l = 4'd3; min_h = 4'd5; min_l = 4'd9;
        state_flag = 3'd5;
        wait_sel(4'b1101, "t2359");
        check_frame(8'h90, 8'h92, 8'hB0, 8'hA4, "t2359_sf5");
        state_flag = 3'd0;

        // Reset mid-frame
        wait_sel(4'b1011, "mid_reset");
        rstn = 1'b0;
        @(negedge clk);
        check_out("mid_reset", 4'b1111, 8'hFF);
        rstn = 1'b1;
        @(negedge clk);
        check_out("mid_reset_restart", 4'b1110, 8'hC0);

        // 09:00 leading zero
        hour_h = 4'd0; hour_l = 4'd9; min_h = 4'd0; min_l = 4'd0;
        wait_sel(4'b1101, "t0900");
        check_frame(8'hC0, 8'hC0, 8'h90, LZ_EXP, "t0900");

        // hour_h under calibration: shows "0" in visible phase, blank after
        wait_sel(4'b1110, "lz_cal");
        state_flag = 3'd4;
        wait_sel(4'b0111, "lz_cal");
        check_out("lz_cal_visible", 4'b0111, 8'hC0);
        wait_sel(4'b1110, "lz_cal");
        wait_sel(4'b0111, "lz_cal");
        check_out("lz_cal_blank", 4'b0111, 8'hFF);
        state_flag = 3'd0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
